sdrv_covox_dac: RTL
===================

Name: sdrv_covox_dac

Overview:
- Sound back-end directly downstream of the I/O port decoder of the expansion board.
- Captures Covox (port #FB) and Soundrive (ports #0F/#1F/#4F/#5F) write strobes into four 8-bit channel registers.
- Mixes the channels into left/right 9-bit sums.
- Drives two 1-bit first-order sigma-delta outputs to the board's RC-filtered audio pins.

Parameters:
- RST_LEVEL, 8'h80, reset/midscale value loaded into every channel register (silence for unsigned samples).

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- addr_lo  input  8  low byte of the Z80 I/O address, valid while a strobe is high
- data_in  input  8  Z80 write data, valid while a strobe is high
- covox_stb  input  1  decoder strobe: write to #FB
- sdrv_stb  input  1  decoder strobe: write to a Soundrive port
- snd_en  input  1  1 = audio active; 0 = outputs forced low, modulators cleared
- ch0..ch3  output  8 each  current channel registers (readback/debug)
- mix_l  output  9  registered left mix
- mix_r  output  9  registered right mix
- dac_l  output  1  left sigma-delta bitstream
- dac_r  output  1  right sigma-delta bitstream

Behaviour:
- Reset (rst_n low, asynchronous):
  - ch0..ch3 = RST_LEVEL.
  - mix_l = mix_r = 9'h100.
  - Both modulator accumulators = 0.
  - dac_l = dac_r = 0.
- Channel write, sampled at each rising edge:
  - sdrv_stb with addr_lo #0F -> ch0, #1F -> ch1, #4F -> ch2, #5F -> ch3.
  - sdrv_stb with any other addr_lo: no write.
  - covox_stb: data_in written to all four channels.
  - covox_stb and sdrv_stb both high: covox write takes precedence and loads all four channels.
  - Strobes may stay high for several clocks. Each cycle rewrites the same value, which is harmless.
  - Writes are accepted regardless of snd_en.
- Mix stage, one register:
  - mix_l <= ch0 + ch1 and mix_r <= ch2 + ch3, unsigned, 9-bit, no overflow possible (max 510).
  - Latency: strobe high in cycle N -> chX updated at edge N -> mix updated at edge N+1 -> first dac bit reflecting the new value at edge N+2.
- Modulator, per side, in sub-module sd_mod:
  - 9-bit accumulator acc.
  - Each edge: {carry, acc} <= acc + mix (10-bit sum); dac <= carry.
  - Ones density = mix/512, exact over a 512-cycle window for constant mix.
  - mix = 0 -> constant 0. mix = 510 -> 510 ones per 512 cycles.
  - Wrap-around of acc is the intended modulo-512 behaviour.
- snd_en:
  - snd_en = 0: acc held at 0 and dac forced 0 on the next edge; channel and mix registers are unaffected.
  - Rising snd_en: modulation restarts from acc = 0.
- Reset mid-stream: all state returns to reset values immediately. No partially written channel value persists.

Decomposition:
- Shared package:
  - Port constants SDRV_P0 = 8'h0F, SDRV_P1 = 8'h1F, SDRV_P2 = 8'h4F, SDRV_P3 = 8'h5F, COVOX_P = 8'hFB.
  - Channel width 8, mix width 9.
  - The decoder also uses these constants.
- Sub-module sd_mod (9-bit in, 1-bit out, clk/rst_n/en), instantiated twice.

Test Plan:
- Reset release, no strobes -> ch0..3 = 8'h80; mix_l = mix_r = 9'h100; after 512 cycles dac_l and dac_r each show exactly 256 ones.
- sdrv_stb, addr_lo #1F, data #FF for 1 cycle -> only ch1 = #FF; mix_l = 9'h17F one edge later; mix_r unchanged at 9'h100.
- covox_stb, data #00 -> all channels #00; mix_l = mix_r = 0; dac_l and dac_r held constant 0 from edge N+2 onward.
- Simultaneous covox_stb and sdrv_stb, addr_lo #4F, data #40 -> all four channels = #40; mix_l = mix_r = 9'h080; 128 ones per 512 cycles on each output.
- snd_en dropped for 10 cycles while mix = 9'h17F -> dac_l = 0 throughout; after re-enable with acc = 0, first carry at cycle 2 and 383 ones per 512 cycles.
- rst_n asserted mid-stream, not aligned to clk, with ch2 = #FF -> ch2 = #80 and dac outputs = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/sdrv_covox_dac_pkg.sv
// Shared constants for the Covox/Soundrive sound path.
// The I/O port decoder uses the same port constants.
package sdrv_covox_dac_pkg;

    localparam int CH_W  = 8;
    localparam int MIX_W = 9;
    localparam int N_CH  = 4;

    localparam logic [7:0] SDRV_P0 = 8'h0F;
    localparam logic [7:0] SDRV_P1 = 8'h1F;
    localparam logic [7:0] SDRV_P2 = 8'h4F;
    localparam logic [7:0] SDRV_P3 = 8'h5F;
    localparam logic [7:0] COVOX_P = 8'hFB;

    // One-hot channel select for a Soundrive write; all zero for foreign ports.
    function automatic logic [N_CH-1:0] sdrv_sel(input logic [7:0] addr);
        logic [N_CH-1:0] sel;
        sel = '0;
        case (addr)
            SDRV_P0: sel = 4'b0001;
            SDRV_P1: sel = 4'b0010;
            SDRV_P2: sel = 4'b0100;
            SDRV_P3: sel = 4'b1000;
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sdrv_covox_dac_if.sv
// Write-strobe bus from the I/O port decoder into the sound back-end.
interface sdrv_covox_dac_if;

    logic [7:0] addr_lo;
    logic [7:0] data_in;
    logic       covox_stb;
    logic       sdrv_stb;

    modport master (output addr_lo, output data_in, output covox_stb, output sdrv_stb);
    modport slave  (input  addr_lo, input  data_in, input  covox_stb, input  sdrv_stb);

endinterface

// File: rtl/sdrv_covox_dac_sd_mod.sv
// First-order 1-bit sigma-delta modulator: ones density equals din/512.
module sd_mod
    import sdrv_covox_dac_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [MIX_W-1:0] din,
    output logic             dout
);

    logic [MIX_W-1:0] acc_p0;
    logic [MIX_W:0]   sum;

    // Accumulator wraps modulo 512; the carry out is the output bit.
    assign sum = {1'b0, acc_p0} + {1'b0, din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p0 <= '0;
            dout   <= 1'b0;
        end else if (!en) begin
            acc_p0 <= '0;
            dout   <= 1'b0;
        end else begin
            acc_p0 <= sum[MIX_W-1:0];
            dout   <= sum[MIX_W];
        end
    end

endmodule

// File: rtl/sdrv_covox_dac.sv
// Covox/Soundrive channel registers, stereo mixer and sigma-delta DAC outputs.
module sdrv_covox_dac
    import sdrv_covox_dac_pkg::*;
#(
    parameter logic [7:0] RST_LEVEL = 8'h80
)
(
    input  logic                clk,
    input  logic                rst_n,
    sdrv_covox_dac_if.slave     bus,
    input  logic                snd_en,
    output logic [CH_W-1:0]     ch0,
    output logic [CH_W-1:0]     ch1,
    output logic [CH_W-1:0]     ch2,
    output logic [CH_W-1:0]     ch3,
    output logic [MIX_W-1:0]    mix_l,
    output logic [MIX_W-1:0]    mix_r,
    output logic                dac_l,
    output logic                dac_r
);

    localparam logic [MIX_W-1:0] MIX_RST = {1'b0, RST_LEVEL} + {1'b0, RST_LEVEL};

    logic [CH_W-1:0] ch_p0 [N_CH];
    logic [N_CH-1:0] sel;

    assign sel = sdrv_sel(bus.addr_lo);

    // Stage p0: channel registers; a Covox write overrides any Soundrive strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) ch_p0[i] <= RST_LEVEL;
        end else if (bus.covox_stb) begin
            for (int i = 0; i < N_CH; i++) ch_p0[i] <= bus.data_in;
        end else if (bus.sdrv_stb) begin
            for (int i = 0; i < N_CH; i++)
                if (sel[i]) ch_p0[i] <= bus.data_in;
        end
    end

    assign ch0 = ch_p0[0];
    assign ch1 = ch_p0[1];
    assign ch2 = ch_p0[2];
    assign ch3 = ch_p0[3];

    // Stage p1: stereo mix, 9 bits so the sum of two channels never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_l <= MIX_RST;
            mix_r <= MIX_RST;
        end else begin
            mix_l <= {1'b0, ch_p0[0]} + {1'b0, ch_p0[1]};
            mix_r <= {1'b0, ch_p0[2]} + {1'b0, ch_p0[3]};
        end
    end

    // Stage p2: modulators.
    sd_mod u_mod_l (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (snd_en),
        .din   (mix_l),
        .dout  (dac_l)
    );

    sd_mod u_mod_r (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (snd_en),
        .din   (mix_r),
        .dout  (dac_r)
    );

endmodule
